// File: rtl/count_display.sv
// Step-counter display back end: sequential binary-to-BCD conversion feeding a
// time-multiplexed three-digit seven-segment display with leading-zero blanking.
module count_display #(
   parameter int SCAN_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  value,
   input  logic        update,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd,
   output logic [6:0]  seg,
   output logic [2:0]  an
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [2:0] AN_OFF  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t          state;
   logic [7:0]      shift;
   logic [11:0]     work;
   logic [2:0]      step;
   logic [11:0]     work_adj;
   logic [CNT_W-1:0] presc;
   logic [1:0]      digit;
   logic [3:0]      nib_p0;
   logic            blank_p0;
   logic [6:0]      seg_p0;
   logic [2:0]      an_p0;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   assign work_adj = {add3(work[11:8]), add3(work[7:4]), add3(work[3:0])};

   // Conversion FSM: capture, eight add-3/shift steps, then publish
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         bcd   <= 12'h000;
         step  <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (update) begin
                  shift <= value;
                  work  <= 12'h000;
                  step  <= 3'd0;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               work  <= {work_adj[10:0], shift[7]};
               shift <= {shift[6:0], 1'b0};
               step  <= step + 3'd1;
               if (step == 3'd7) state <= LOAD;
            end
            LOAD: begin
               bcd   <= work;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Scan prescaler and digit index, free-running beside the FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
         digit <= 2'd0;
      end else if (presc == CNT_MAX) begin
         presc <= '0;
         digit <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
      end else begin
         presc <= presc + CNT_W'(1);
      end
   end

   always_comb begin
      nib_p0   = bcd[3:0];
      blank_p0 = 1'b0;
      case (digit)
         2'd0: nib_p0 = bcd[3:0];
         2'd1: begin
            nib_p0   = bcd[7:4];
            blank_p0 = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
         end
         2'd2: begin
            nib_p0   = bcd[11:8];
            blank_p0 = (bcd[11:8] == 4'd0);
         end
         default: blank_p0 = 1'b1;
      endcase
      seg_p0 = blank_p0 ? 7'h00 : seg7(nib_p0);
      an_p0  = blank_p0 ? 3'b000 : (3'b001 << digit);
   end

   // Registered segment/anode drive, one cycle behind digit index and bcd
   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= (ACTIVE_LOW != 0) ? ~seg_p0 : seg_p0;
         an  <= (ACTIVE_LOW != 0) ? ~an_p0 : an_p0;
      end
   end

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display with a fast scan rate and an arithmetic decimal model.
module tb_count_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  value = 8'd0;
   logic        update = 1'b0;
   logic        busy, done;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic [2:0]  an;

   int passed = 0;
   int total  = 0;

   localparam int SD = 4;

   count_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .value(value), .update(update),
      .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] model_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic [6:0] glyph(input int d);
      logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      return t[d];
   endfunction

   task automatic pulse_update(input logic [7:0] v);
      @(negedge clk);
      value  = v;
      update = 1'b1;
      @(negedge clk);
      update = 1'b0;
   endtask

   // Observe one full frame and check every lit digit and every blank slot.
   task automatic check_frame(input string name, input int v);
      int cnt [3];
      int bad = 0;
      int dg [3];
      bit vis [3];
      dg[0] = v % 10; dg[1] = (v / 10) % 10; dg[2] = v / 100;
      vis[0] = 1'b1; vis[1] = (v >= 10); vis[2] = (v >= 100);
      cnt = '{0, 0, 0};
      for (int c = 0; c < 3 * SD; c++) begin
         @(negedge clk);
         case (an)
            3'b111: if (seg !== 7'h7F) bad++;
            3'b110: begin cnt[0]++; if (seg !== ~glyph(dg[0])) bad++; end
            3'b101: begin cnt[1]++; if (seg !== ~glyph(dg[1])) bad++; end
            3'b011: begin cnt[2]++; if (seg !== ~glyph(dg[2])) bad++; end
            default: bad++;
         endcase
      end
      total++;
      if (bad !== 0) $display("FAIL %s frame_pattern: %0d bad cycles, required 0", name, bad);
      else passed++;
      for (int d = 0; d < 3; d++) begin
         total++;
         if (cnt[d] !== (vis[d] ? SD : 0))
            $display("FAIL %s an%0d_cycles: got %0d, required %0d", name, d, cnt[d], vis[d] ? SD : 0);
         else passed++;
      end
   endtask

   // One conversion with full latency checks; returns after the done cycle.
   task automatic convert(input string name, input int v);
      int busy_bad = 0;
      pulse_update(8'(v));
      for (int i = 0; i < 9; i++) begin
         if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
         @(negedge clk);
      end
      total++;
      if (busy_bad !== 0) $display("FAIL %s busy_window: %0d bad cycles, required 0", name, busy_bad);
      else passed++;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || bcd !== model_bcd(v))
         $display("FAIL %s result: done=%b busy=%b bcd=%h, required done=1 busy=0 bcd=%h",
                  name, done, busy, bcd, model_bcd(v));
      else passed++;
      @(negedge clk);
      total++;
      if (done !== 1'b0) $display("FAIL %s done_width: done=%b, required 0", name, done);
      else passed++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || seg !== 7'h7F || an !== 3'b111)
         $display("FAIL reset_state: busy=%b done=%b bcd=%h seg=%h an=%b, required 0 0 000 7f 111",
                  busy, done, bcd, seg, an);
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (an !== 3'b110 || seg !== 7'h40)
         $display("FAIL first_digit: an=%b seg=%h, required an=110 seg=40", an, seg);
      else passed++;
      check_frame("idle", 0);
   endtask

   task automatic test_max();
      convert("v255", 255);
      check_frame("v255", 255);
   endtask

   task automatic test_small();
      convert("v7", 7);
      check_frame("v7", 7);
   endtask

   task automatic test_ignore();
      int dones = 0;
      pulse_update(8'd100);
      @(negedge clk);
      value = 8'd42; update = 1'b1;
      @(negedge clk);
      update = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) dones++;
         @(negedge clk);
      end
      total++;
      if (dones !== 1 || bcd !== 12'h100)
         $display("FAIL ignore_busy: dones=%0d bcd=%h, required 1 and 100", dones, bcd);
      else passed++;
      convert("v42", 42);
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      pulse_update(8'd199);
      repeat (3) @(negedge clk);
      rst = 1'b1; update = 1'b1; value = 8'd77;
      @(negedge clk);
      rst = 1'b0; update = 1'b0;
      total++;
      if (busy !== 1'b0 || bcd !== 12'h000 || done !== 1'b0)
         $display("FAIL reset_mid: busy=%b bcd=%h done=%b, required 0 000 0", busy, bcd, done);
      else passed++;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) dones++;
      end
      total++;
      if (dones !== 0) $display("FAIL reset_mid_quiet: %0d active cycles, required 0", dones);
      else passed++;
      check_frame("after_rst", 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 12; k++) begin
         int v = int'($urandom_range(0, 255));
         convert($sformatf("rnd%0d", v), v);
         if (k % 4 == 0) check_frame($sformatf("rnd%0d", v), v);
      end
   endtask

   task automatic test_sweep();
      int errs = 0;
      int to = 0;
      for (int v = 0; v < 256; v++) begin
         int w = 0;
         pulse_update(8'(v));
         while (done !== 1'b1 && w < 30) begin @(negedge clk); w++; end
         if (w >= 30) to++;
         else if (bcd !== model_bcd(v)) begin
            errs++;
            $display("FAIL sweep_%0d: bcd=%h, required %h", v, bcd, model_bcd(v));
         end
      end
      total++;
      if (errs !== 0 || to !== 0) $display("FAIL sweep: %0d wrong, %0d timeouts, required 0", errs, to);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_max();
      test_small();
      test_ignore();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
